ammo_supply: RTL and testbench
==============================

Name: ammo_supply

Overview:
- Resupply controller: the producer end of the weapons ammo-load interface.
- Watches the weapon's current ammo count and, when ammo runs low or on manual request, moves rounds in chunks from a finite onboard depot into the weapon.
- Drives the weapon's ammo value and load strobe. Accepts depot restock deliveries from the cargo side through a valid/ready handshake.

Parameters:
- N, 9, ammo count width (matches the weapon counter)
- D, 12, depot stock width
- MAX_AMMO, 511, weapon magazine capacity
- CHUNK, 16, maximum rounds granted per load
- LOW_THRESH, 32, auto-resupply triggers when ammo_level < LOW_THRESH
- DEPOT_INIT, 2000, depot stock after reset
- COOLDOWN, 4, idle cycles enforced after a transfer ends

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ammo_level  in  N  current weapon ammo count (weapon counter output)
- fire  in  1  weapon trigger; loads are withheld while high
- manual_req  in  1  level request; starts a transfer regardless of threshold
- restock_valid  in  1  depot delivery offered
- restock_amount  in  D  rounds in the delivery
- restock_ready  out  1  delivery accepted when valid&&ready on a clk edge
- ammo_out  out  N  new ammo value presented to the weapon
- load_ammo  out  1  one-cycle load strobe to the weapon
- stock  out  D  current depot stock
- busy  out  1  high in XFER, SETTLE and COOL
- depleted  out  1  stock==0
- xfer_done  out  1  one-cycle pulse when a transfer ends

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, stock=DEPOT_INIT, ammo_out=0, load_ammo=0, busy=0, xfer_done=0, depleted=(DEPOT_INIT==0), restock_ready=1. rst overrides every other input in the same cycle, including mid-transfer: no load issued, grants not yet loaded are lost, stock keeps DEPOT_INIT.
- FSM states: IDLE, XFER, SETTLE, COOL.
- IDLE:
  - Go to XFER when (ammo_level<LOW_THRESH || manual_req) && stock!=0 && ammo_level<MAX_AMMO.
  - If stock==0, stay in IDLE; depleted=1.
- XFER (per cycle):
  - If fire==1: no load; stay in XFER (pause).
  - Else compute grant = min(CHUNK, MAX_AMMO-ammo_level, stock).
  - If grant>0: next cycle load_ammo=1, ammo_out=ammo_level+grant, stock-=grant; go to SETTLE.
  - If grant==0 (full or empty): go to COOL and pulse xfer_done for 1 cycle.
- SETTLE: exactly one cycle, so the weapon registers the load and ammo_level updates; load_ammo returns to 0; then go to XFER.
- Load latency: load_ammo is high the cycle after the grant decision. The weapon latches at the end of that cycle; the updated ammo_level is visible one cycle later.
- Grant arithmetic: computed in D+1 bits; ammo_out never exceeds MAX_AMMO; stock never underflows.
- COOL: count COOLDOWN cycles, then go to IDLE. manual_req is ignored in COOL.
- Restock handshake:
  - restock_ready = (state==IDLE || state==COOL).
  - On accept, stock = min(stock+restock_amount, 2^D-1) (saturating).
  - Grant and restock never coincide, because ready is low in XFER and SETTLE.
- depleted tracks stock==0 combinationally from the stock register; it clears on the edge a nonzero restock is accepted.
- fire held for the whole transfer keeps the block in XFER indefinitely (no timeout).

Test Plan:
- rst; ammo_level=500, manual_req=1 -> one load_ammo pulse with ammo_out=511; stock 2000->1989; xfer_done pulses; busy low after 4 COOL cycles.
- rst; restock stock to 5; ammo_level=10 (auto trigger) -> single grant: ammo_out=15, stock=0, depleted=1, xfer_done; a second low-ammo trigger in IDLE does not start XFER.
- ammo_level=0, stock 2000, weapon model echoing ammo_out -> loads of 16 rounds every 2 cycles (ammo_out=16,32,...); 31 full chunks then a final 15 reaching 511; stock=1489.
- During XFER assert fire for 5 cycles -> no load_ammo in those cycles; loading resumes the cycle after fire falls, with unchanged chunk sequence.
- stock=4090, restock_amount=100 valid in IDLE -> stock=4095 (saturated); restock_valid during XFER -> ready=0, not accepted until COOL.
- Assert rst in the SETTLE cycle -> next cycle state=IDLE, load_ammo=0, stock=2000, busy=0.

Source files
------------

// File: rtl/ammo_supply.sv
// rtl/ammo_supply.sv - ammo resupply controller driving the weapon load interface
// Moves rounds in chunks from a finite depot into the weapon; depot restocked via valid/ready.
module ammo_supply #(
   parameter int N          = 9,
   parameter int D          = 12,
   parameter int MAX_AMMO   = 511,
   parameter int CHUNK      = 16,
   parameter int LOW_THRESH = 32,
   parameter int DEPOT_INIT = 2000,
   parameter int COOLDOWN   = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] ammo_level,
   input  logic         fire,
   input  logic         manual_req,
   input  logic         restock_valid,
   input  logic [D-1:0] restock_amount,
   output logic         restock_ready,
   output logic [N-1:0] ammo_out,
   output logic         load_ammo,
   output logic [D-1:0] stock,
   output logic         busy,
   output logic         depleted,
   output logic         xfer_done
);

   localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

   localparam logic [D:0]    L_MAX       = (D+1)'(MAX_AMMO);
   localparam logic [D:0]    L_CHUNK     = (D+1)'(CHUNK);
   localparam logic [D:0]    L_LOW       = (D+1)'(LOW_THRESH);
   localparam logic [D-1:0]  L_INIT      = D'(DEPOT_INIT);
   localparam logic [CW-1:0] L_COOL_LAST = CW'(COOLDOWN - 1);

   typedef enum logic [1:0] {IDLE, XFER, SETTLE, COOL} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [D-1:0]  r_stock;
   logic [D-1:0]  w_stock_nxt;
   logic [N-1:0]  r_ammo_out;
   logic [N-1:0]  w_ammo_out_nxt;
   logic          r_load;
   logic          w_load_nxt;
   logic          r_done;
   logic          w_done_nxt;
   logic [CW-1:0] r_cool_cnt;
   logic [CW-1:0] w_cool_cnt_nxt;

   logic [D:0]    w_level;
   logic [D:0]    w_room;
   logic [D:0]    w_stock_ext;
   logic [D:0]    w_grant;
   logic [D:0]    w_restock_sum;
   logic          w_grant_zero;
   logic          w_trigger;
   logic          w_cool_last;
   logic          w_accept;

   // Grant math is done one bit wider than the depot so nothing can wrap.
   assign w_level       = (D+1)'(ammo_level);
   assign w_stock_ext   = {1'b0, r_stock};
   assign w_room        = (w_level >= L_MAX) ? '0 : (L_MAX - w_level);
   assign w_restock_sum = w_stock_ext + (D+1)'(restock_amount);

   always_comb begin
      w_grant = L_CHUNK;
      if (w_room < w_grant) begin
         w_grant = w_room;
      end
      if (w_stock_ext < w_grant) begin
         w_grant = w_stock_ext;
      end
   end

   assign w_grant_zero = (w_grant == '0);
   assign w_trigger    = ((w_level < L_LOW) || manual_req) && (r_stock != '0) && (w_level < L_MAX);
   assign w_cool_last  = (r_cool_cnt == L_COOL_LAST);
   assign w_accept     = restock_valid && restock_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_trigger) begin
               w_state_nxt = XFER;
            end
         end
         XFER: begin
            if (!fire) begin
               w_state_nxt = w_grant_zero ? COOL : SETTLE;
            end
         end
         SETTLE: begin
            w_state_nxt = XFER;
         end
         COOL: begin
            if (w_cool_last) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      w_load_nxt     = 1'b0;
      w_done_nxt     = 1'b0;
      w_ammo_out_nxt = r_ammo_out;
      w_stock_nxt    = r_stock;
      w_cool_cnt_nxt = '0;
      case (r_state)
         XFER: begin
            if (!fire) begin
               if (!w_grant_zero) begin
                  w_load_nxt     = 1'b1;
                  w_ammo_out_nxt = ammo_level + w_grant[N-1:0];
                  w_stock_nxt    = r_stock - w_grant[D-1:0];
               end else begin
                  w_done_nxt = 1'b1;
               end
            end
         end
         COOL: begin
            w_cool_cnt_nxt = w_cool_last ? '0 : (r_cool_cnt + 1'b1);
         end
         default: begin
         end
      endcase
      // Ready is low in XFER/SETTLE, so an accept never collides with a grant.
      if (w_accept) begin
         w_stock_nxt = w_restock_sum[D] ? '1 : w_restock_sum[D-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stock    <= L_INIT;
         r_ammo_out <= '0;
         r_load     <= 1'b0;
         r_done     <= 1'b0;
         r_cool_cnt <= '0;
      end else begin
         r_stock    <= w_stock_nxt;
         r_ammo_out <= w_ammo_out_nxt;
         r_load     <= w_load_nxt;
         r_done     <= w_done_nxt;
         r_cool_cnt <= w_cool_cnt_nxt;
      end
   end

   assign ammo_out      = r_ammo_out;
   assign load_ammo     = r_load;
   assign xfer_done     = r_done;
   assign stock         = r_stock;
   assign depleted      = (r_stock == '0);
   assign busy          = (r_state != IDLE);
   assign restock_ready = (r_state == IDLE) || (r_state == COOL);

endmodule

// File: tb/tb_ammo_supply.sv
// tb/tb_ammo_supply.sv - self-checking bench for ammo_supply
// Vector table, directed multi-cycle sequences and a random run against a depot/weapon model.
module tb_ammo_supply;

   logic        clk = 1'b0;
   logic        rst;
   logic [8:0]  ammo_level;
   logic        fire;
   logic        manual_req;
   logic        restock_valid;
   logic [11:0] restock_amount;
   logic        restock_ready;
   logic [8:0]  ammo_out;
   logic        load_ammo;
   logic [11:0] stock;
   logic        busy;
   logic        depleted;
   logic        xfer_done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ammo_supply dut (
      .clk            (clk),
      .rst            (rst),
      .ammo_level     (ammo_level),
      .fire           (fire),
      .manual_req     (manual_req),
      .restock_valid  (restock_valid),
      .restock_amount (restock_amount),
      .restock_ready  (restock_ready),
      .ammo_out       (ammo_out),
      .load_ammo      (load_ammo),
      .stock          (stock),
      .busy           (busy),
      .depleted       (depleted),
      .xfer_done      (xfer_done)
   );

   typedef struct {
      int level;
      bit manual;
      bit exp_load;
      int exp_out;
      int exp_stock;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic echo();
      if (load_ammo) ammo_level = ammo_out;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      fire           = 1'b0;
      manual_req     = 1'b0;
      restock_valid  = 1'b0;
      restock_amount = '0;
      ammo_level     = 9'd511;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int loads, k, last_k_cyc, cyc, waited, g, stock_m, lvl_prev, amt_prev, lvl;
      bit acc_prev, fire_prev, done, bad;

      vecs[0] = '{500, 1'b1, 1'b1, 511, 1989};
      vecs[1] = '{31,  1'b0, 1'b1, 47,  1984};
      vecs[2] = '{32,  1'b0, 1'b0, 0,   2000};
      vecs[3] = '{511, 1'b1, 1'b0, 0,   2000};
      vecs[4] = '{0,   1'b0, 1'b1, 16,  1984};
      vecs[5] = '{100, 1'b1, 1'b1, 116, 1984};
      vecs[6] = '{505, 1'b1, 1'b1, 511, 1994};
      vecs[7] = '{40,  1'b0, 1'b0, 0,   2000};

      // Reset state
      do_reset();
      check("rst_stock", stock, 2000);
      check("rst_ammo_out", ammo_out, 0);
      check("rst_load", load_ammo, 0);
      check("rst_busy", busy, 0);
      check("rst_done", xfer_done, 0);
      check("rst_depleted", depleted, 0);
      check("rst_ready", restock_ready, 1);

      // Trigger-decision vectors: first grant lands two edges after the request
      for (int i = 0; i < 8; i++) begin
         do_reset();
         ammo_level = 9'(vecs[i].level);
         manual_req = vecs[i].manual;
         tick();
         check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_load);
         tick();
         check($sformatf("vec%0d_load", i), load_ammo, vecs[i].exp_load);
         check($sformatf("vec%0d_ammo_out", i), ammo_out, vecs[i].exp_out);
         check($sformatf("vec%0d_stock", i), stock, vecs[i].exp_stock);
      end

      // Single top-up from 500, then exactly COOLDOWN busy cycles
      do_reset();
      ammo_level = 9'd500;
      manual_req = 1'b1;
      loads = 0;
      done  = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         tick();
         if (load_ammo) begin
            loads++;
            check("s1_ammo_out", ammo_out, 511);
         end
         echo();
         done = xfer_done;
      end
      check("s1_done_seen", done, 1);
      check("s1_loads", loads, 1);
      check("s1_stock", stock, 1989);
      check("s1_busy_cool1", busy, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("s1_busy_cool", busy, 1);
         check("s1_done_once", xfer_done, 0);
      end
      tick();
      check("s1_busy_after_cool", busy, 0);
      tick();
      tick();
      check("s1_full_stays_idle", busy, 0);
      manual_req = 1'b0;

      // Drain depot with weapon stuck at zero, restock 5, then one partial grant
      do_reset();
      ammo_level = 9'd0;
      loads = 0;
      done  = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         tick();
         if (load_ammo) loads++;
         done = xfer_done;
      end
      check("s2_drain_done", done, 1);
      check("s2_drain_loads", loads, 125);
      check("s2_drain_stock", stock, 0);
      check("s2_drain_depleted", depleted, 1);
      restock_valid  = 1'b1;
      restock_amount = 12'd5;
      ammo_level     = 9'd10;
      tick();
      restock_valid = 1'b0;
      check("s2_restock_stock", stock, 5);
      check("s2_restock_depleted", depleted, 0);
      loads = 0;
      done  = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         tick();
         if (load_ammo) begin
            loads++;
            check("s2_partial_out", ammo_out, 15);
            check("s2_partial_stock", stock, 0);
            check("s2_partial_depleted", depleted, 1);
         end
         echo();
         done = xfer_done;
      end
      check("s2_partial_done", done, 1);
      check("s2_partial_loads", loads, 1);
      for (int i = 0; i < 4; i++) tick();
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (busy) bad = 1'b1;
      end
      check("s2_empty_no_restart", bad, 0);

      // Full load from zero with weapon echo: 31 chunks of 16, then 15
      do_reset();
      ammo_level = 9'd0;
      k          = 0;
      last_k_cyc = 0;
      done       = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         tick();
         if (load_ammo) begin
            k++;
            check($sformatf("s3_chunk%0d", k), ammo_out, (k <= 31) ? 16 * k : 511);
            if (k > 1) check("s3_spacing", i - last_k_cyc, 2);
            last_k_cyc = i;
         end
         echo();
         done = xfer_done;
      end
      check("s3_done", done, 1);
      check("s3_loads", k, 32);
      check("s3_stock", stock, 1489);

      // Fire pause mid-transfer
      do_reset();
      ammo_level = 9'd0;
      k = 0;
      for (int i = 0; i < 20 && k < 2; i++) begin
         tick();
         if (load_ammo) k++;
         echo();
      end
      check("s4_two_loads", k, 2);
      fire = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("s4_no_load_fire", load_ammo, 0);
      end
      fire = 1'b0;
      tick();
      check("s4_resume_load", load_ammo, 1);
      check("s4_resume_out", ammo_out, 48);
      check("s4_resume_stock", stock, 1952);

      // Saturating restock, then ready held low through XFER/SETTLE
      do_reset();
      restock_valid  = 1'b1;
      restock_amount = 12'd2090;
      tick();
      check("s5_stock_4090", stock, 4090);
      restock_amount = 12'd100;
      tick();
      check("s5_saturate", stock, 4095);
      restock_valid = 1'b0;
      ammo_level    = 9'd500;
      manual_req    = 1'b1;
      tick();
      restock_valid  = 1'b1;
      restock_amount = 12'd3;
      waited = 0;
      while (!restock_ready && waited < 20) begin
         tick();
         echo();
         waited++;
      end
      check("s5_ready_wait", waited, 3);
      check("s5_stock_before_accept", stock, 4084);
      check("s5_accept_in_cool", busy, 1);
      tick();
      restock_valid = 1'b0;
      manual_req    = 1'b0;
      check("s5_stock_after_accept", stock, 4087);

      // Reset during SETTLE
      do_reset();
      ammo_level = 9'd0;
      k = 0;
      for (int i = 0; i < 10 && k == 0; i++) begin
         tick();
         if (load_ammo) k = 1;
      end
      check("s6_reached_settle", k, 1);
      rst = 1'b1;
      tick();
      check("s6_load", load_ammo, 0);
      check("s6_stock", stock, 2000);
      check("s6_busy", busy, 0);
      check("s6_ammo_out", ammo_out, 0);
      rst        = 1'b0;
      ammo_level = 9'd511;

      // Random run against depot/weapon model
      do_reset();
      ammo_level = 9'($urandom_range(0, 511));
      stock_m    = 2000;
      acc_prev   = 1'b0;
      amt_prev   = 0;
      lvl_prev   = int'(ammo_level);
      fire_prev  = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (acc_prev) stock_m = imin(stock_m + amt_prev, 4095);
         if (load_ammo) begin
            g = imin(imin(16, 511 - lvl_prev), stock_m);
            check("rnd_fire_gate", fire_prev, 0);
            check("rnd_grant_nonzero", (g > 0) ? 1 : 0, 1);
            check("rnd_ammo_out", ammo_out, lvl_prev + g);
            check("rnd_ready_low", restock_ready, 0);
            stock_m -= g;
            ammo_level = ammo_out;
         end
         check("rnd_stock", stock, stock_m);
         check("rnd_depleted", depleted, (stock_m == 0) ? 1 : 0);
         manual_req = ($urandom_range(0, 7) == 0);
         fire       = ($urandom_range(0, 3) == 0);
         if (fire && !load_ammo) begin
            lvl = int'(ammo_level) - int'($urandom_range(0, 3));
            ammo_level = 9'((lvl < 0) ? 0 : lvl);
         end
         restock_valid  = ($urandom_range(0, 15) == 0);
         restock_amount = 12'($urandom_range(0, 300));
         acc_prev  = restock_valid && restock_ready;
         amt_prev  = int'(restock_amount);
         lvl_prev  = int'(ammo_level);
         fire_prev = fire;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
